// File: rtl/sn76489_latch_ctrl.sv
// sn76489_latch_ctrl
//   CPU-side front end of the SN76489 model. Divides clock_i down to the shared channel
//   clock enable, samples CPU writes on ce_n_i/wr_n_i, decodes latch/data bytes against the
//   internally latched register address, and drives a one-tick write strobe plus r2/data to
//   the selected channel. Also models the READY output of the chip.
//
// Ports
//   clock_i     system clock (single domain)
//   res_i       asynchronous active-high reset
//   ce_n_i      chip enable, active low
//   wr_n_i      write strobe, active low
//   d_i         CPU data, bit 0 is the MSB
//   clk_en_o    channel clock enable, one clock_i cycle every CLK_DIV cycles
//   ready_o     1 = idle, 0 = write in progress
//   tone1_we_o  write strobe, tone channel 1
//   tone2_we_o  write strobe, tone channel 2
//   tone3_we_o  write strobe, tone channel 3
//   noise_we_o  write strobe, noise channel
//   r2_o        0 = frequency/control register, 1 = attenuator register
//   d_o         byte forwarded to the channels, bit 0 is the MSB
module sn76489_latch_ctrl #(
  parameter int unsigned CLK_DIV     = 16,
  parameter int unsigned READY_TICKS = 2
) (
  input  logic       clock_i,
  input  logic       res_i,
  input  logic       ce_n_i,
  input  logic       wr_n_i,
  input  logic [0:7] d_i,
  output logic       clk_en_o,
  output logic       ready_o,
  output logic       tone1_we_o,
  output logic       tone2_we_o,
  output logic       tone3_we_o,
  output logic       noise_we_o,
  output logic       r2_o,
  output logic [0:7] d_o
);

  localparam int unsigned DivW  = $clog2(CLK_DIV);
  localparam int unsigned TickW = $clog2(READY_TICKS + 1);

  localparam logic [DivW-1:0]  DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(READY_TICKS);

  typedef enum logic [1:0] {
    StIdle,
    StPend,
    StBusy,
    StRel
  } state_e;

  // --------------------------------------------------------------------------
  // Clock-enable divider
  // --------------------------------------------------------------------------
  logic [DivW-1:0] div_q, div_d;
  logic            clk_en_q, clk_en_d;

  always_comb begin
    div_d    = (div_q == DivLast) ? '0 : div_q + DivW'(1);
    // Registered from the next count so the pulse lines up with div_q == CLK_DIV-1.
    clk_en_d = (div_d == DivLast);
  end

  always_ff @(posedge clock_i or posedge res_i) begin
    if (res_i) begin
      div_q    <= '0;
      clk_en_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      clk_en_q <= clk_en_d;
    end
  end

  assign clk_en_o = clk_en_q;

  // --------------------------------------------------------------------------
  // Write FSM
  // --------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic             ready_q, ready_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic [TickW-1:0] tick_inc;
  logic [0:7]       byte_q, byte_d;
  logic [0:2]       reg_q, reg_d;
  logic             r2_q, r2_d;
  logic [0:7]       dout_q, dout_d;

  logic             access;
  logic             commit;
  logic             is_latch;
  logic [0:1]       sel_ch;
  logic             sel_r2;

  assign access   = ~ce_n_i & ~wr_n_i;
  assign tick_inc = tick_q + TickW'(1);

  // The pending byte is committed in the first clk_en cycle seen while in PEND.
  assign commit   = (state_q == StPend) & clk_en_q;
  assign is_latch = byte_q[0];
  assign sel_ch   = is_latch ? byte_q[1:2] : reg_q[0:1];
  assign sel_r2   = is_latch ? byte_q[3]   : reg_q[2];

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    tick_d  = tick_q;
    byte_d  = byte_q;
    unique case (state_q)
      StIdle: begin
        if (access) begin
          byte_d  = d_i;
          ready_d = 1'b0;
          state_d = StPend;
        end
      end
      StPend: begin
        if (clk_en_q) begin
          tick_d  = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (clk_en_q) begin
          tick_d = tick_inc;
          if (tick_inc == TickLast) begin
            ready_d = 1'b1;
            // Still-held access must be released before another write is accepted.
            state_d = access ? StRel : StIdle;
          end
        end
      end
      StRel: begin
        if (!access) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Commit datapath: register address only moves on latch bytes.
  always_comb begin
    reg_d  = reg_q;
    r2_d   = r2_q;
    dout_d = dout_q;
    if (commit) begin
      if (is_latch) begin
        reg_d = byte_q[1:3];
      end
      r2_d   = sel_r2;
      dout_d = byte_q;
    end
  end

  always_ff @(posedge clock_i or posedge res_i) begin
    if (res_i) begin
      state_q <= StIdle;
      ready_q <= 1'b1;
      tick_q  <= '0;
      byte_q  <= '0;
      reg_q   <= '0;
      r2_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      tick_q  <= tick_d;
      byte_q  <= byte_d;
      reg_q   <= reg_d;
      r2_q    <= r2_d;
      dout_q  <= dout_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: r2/data are valid in the commit cycle itself, then held.
  // --------------------------------------------------------------------------
  always_comb begin
    tone1_we_o = 1'b0;
    tone2_we_o = 1'b0;
    tone3_we_o = 1'b0;
    noise_we_o = 1'b0;
    if (commit) begin
      unique case (sel_ch)
        2'b00:   tone1_we_o = 1'b1;
        2'b01:   tone2_we_o = 1'b1;
        2'b10:   tone3_we_o = 1'b1;
        default: noise_we_o = 1'b1;
      endcase
    end
  end

  assign r2_o    = commit ? sel_r2 : r2_q;
  assign d_o     = commit ? byte_q : dout_q;
  assign ready_o = ready_q;

  strobe_onehot_a : assert property (@(posedge clock_i) disable iff (res_i)
    $onehot0({tone1_we_o, tone2_we_o, tone3_we_o, noise_we_o}));

endmodule
